// File: rtl/commutation_pkg.sv
// Shared types, sector table and step arithmetic for the six-step commutation sequencer.
package commutation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BRAKE = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  // Encoding is {high, low} so an applied leg maps straight onto the gate pair.
  typedef enum logic [1:0] {
    LEG_OFF  = 2'b00,
    LEG_LOW  = 2'b01,
    LEG_HIGH = 2'b10
  } leg_t;

  localparam logic [0:5][5:0] SECTOR_LUT = {
    6'b001100, 6'b010100, 6'b010001, 6'b100001, 6'b100010, 6'b001010
  };

  localparam logic [5:0] BRAKE_PATTERN = 6'b000111;

  function automatic logic [2:0] step_inc(input logic [2:0] s);
    return (s >= 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] step_dec(input logic [2:0] s);
    return (s == 3'd0 || s > 3'd5) ? 3'd5 : s - 3'd1;
  endfunction

  function automatic leg_t phase_leg(input logic [5:0] pattern, input logic [1:0] phase);
    if (pattern[3'(phase) + 3'd3]) return LEG_HIGH;
    if (pattern[3'(phase)])        return LEG_LOW;
    return LEG_OFF;
  endfunction

endpackage

// File: rtl/phase_deadtime.sv
// One bridge phase: applies the commanded leg, inserting K_DEADTIME off cycles on high<->low swaps.
module phase_deadtime
  import commutation_pkg::*;
#(
  parameter int K_DEADTIME = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  leg_t i_leg_cmd,
  output logic o_high,
  output logic o_low
);

  localparam int CW = (K_DEADTIME > 0) ? $clog2(K_DEADTIME + 1) : 1;
  localparam logic [CW-1:0] DT_LOAD = CW'(K_DEADTIME);

  leg_t          cmd;
  leg_t          applied_q;
  leg_t          orig_q;
  logic [CW-1:0] cnt_q;

  assign cmd = (i_leg_cmd == LEG_HIGH || i_leg_cmd == LEG_LOW) ? i_leg_cmd : LEG_OFF;

  // While counting, orig_q remembers the departed leg so a return to it aborts the gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      applied_q <= LEG_OFF;
      orig_q    <= LEG_OFF;
      cnt_q     <= '0;
    end else if (cnt_q != '0) begin
      if (cmd == orig_q) begin
        applied_q <= orig_q;
        cnt_q     <= '0;
      end else if (cmd == LEG_OFF) begin
        applied_q <= LEG_OFF;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) applied_q <= cmd;
      end
    end else if ((K_DEADTIME > 0) && (applied_q != LEG_OFF) &&
                 (cmd != LEG_OFF) && (cmd != applied_q)) begin
      orig_q    <= applied_q;
      applied_q <= LEG_OFF;
      cnt_q     <= DT_LOAD;
    end else begin
      applied_q <= cmd;
    end
  end

  assign {o_high, o_low} = applied_q;

endmodule

// File: rtl/commutation_sequencer.sv
// Six-step BLDC commutation sequencer: encoder sector tracking, run/brake/idle FSM, dead time.
// Optional stall watchdog enabled by defining STALL_DETECT_EN.
module commutation_sequencer
  import commutation_pkg::*;
#(
  parameter int K_NSUBSTEPS    = 10,
  parameter int K_DEADTIME     = 4,
  parameter int K_STALL_CYCLES = 1000000
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_enable,
  input  logic                               i_brake,
  input  logic                               i_direction,
  input  logic                               i_step_trigger,
  input  logic                               i_step_dir,
  input  logic                               i_polarity_rev,
  input  logic [2:0]                         i_force_step_value,
  input  logic                               i_force_step_trigger,
  input  logic [$clog2(K_NSUBSTEPS+1)-1:0]   i_power,
  output logic [5:0]                         o_pattern,
  output logic [2:0]                         o_step,
  output logic [$clog2(K_NSUBSTEPS)-1:0]     o_substep,
  output logic                               o_commutate,
  output logic [1:0]                         o_state,
  output logic                               o_fault
);

  localparam int PW = $clog2(K_NSUBSTEPS + 1);
  localparam int SW = $clog2(K_NSUBSTEPS);
  localparam logic [SW-1:0] SUB_MAX = SW'(K_NSUBSTEPS - 1);

  if (K_NSUBSTEPS < 2 || K_DEADTIME < 0 || K_STALL_CYCLES < 1) begin : g_bad_config
    $error("commutation_sequencer: invalid parameter set");
  end

  logic [2:0]    step_q;
  logic [SW-1:0] substep_q;
  logic          commutate_q;
  state_t        state_q;
  logic          fault_q;
  logic          stall_hit;
  logic          tick_up;
  logic          force_valid;
  logic [2:0]    drive_step;
  logic          high_en;
  logic [5:0]    cmd_pattern;
  logic [2:0]    gate_high;
  logic [2:0]    gate_low;

  assign tick_up     = ~(i_step_dir ^ i_polarity_rev);
  assign force_valid = i_force_step_trigger && (i_force_step_value <= 3'd5);

  // Position tracking runs regardless of FSM state; a valid force swallows a same-cycle tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_q      <= 3'd5;
      substep_q   <= '0;
      commutate_q <= 1'b0;
    end else begin
      commutate_q <= 1'b0;
      if (force_valid) begin
        step_q    <= i_force_step_value;
        substep_q <= '0;
      end else if (i_step_trigger) begin
        if (tick_up) begin
          if (substep_q == SUB_MAX) begin
            substep_q   <= '0;
            step_q      <= step_inc(step_q);
            commutate_q <= 1'b1;
          end else begin
            substep_q <= substep_q + SW'(1);
          end
        end else begin
          if (substep_q == '0) begin
            substep_q   <= SUB_MAX;
            step_q      <= step_dec(step_q);
            commutate_q <= 1'b1;
          end else begin
            substep_q <= substep_q - SW'(1);
          end
        end
      end
    end
  end

`ifdef STALL_DETECT_EN
  localparam int WW = $clog2(K_STALL_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(K_STALL_CYCLES - 1);

  logic [WW-1:0] wdog_q;
  logic          run_entry;

  assign run_entry = i_enable && !i_brake && (state_q == ST_IDLE || state_q == ST_BRAKE);
  assign stall_hit = (state_q == ST_RUN) && !i_step_trigger && (wdog_q == WDOG_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdog_q <= '0;
    end else if (i_step_trigger || run_entry) begin
      wdog_q <= '0;
    end else if (state_q == ST_RUN && wdog_q != WDOG_LAST) begin
      wdog_q <= wdog_q + WW'(1);
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Losing enable overrides everything, including a latched fault.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      fault_q <= 1'b0;
    end else if (!i_enable) begin
      state_q <= ST_IDLE;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_BRAKE: state_q <= i_brake ? ST_BRAKE : ST_RUN;
        ST_RUN: begin
          if (stall_hit) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end else if (i_brake) begin
            state_q <= ST_BRAKE;
          end
        end
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    drive_step  = i_direction ? step_dec(step_q) : step_inc(step_q);
    high_en     = (i_power > PW'(substep_q));
    cmd_pattern = '0;
    case (state_q)
      ST_RUN: begin
        cmd_pattern = SECTOR_LUT[drive_step];
        if (!high_en) cmd_pattern[5:3] = 3'b000;
      end
      ST_BRAKE: cmd_pattern = BRAKE_PATTERN;
      default:  cmd_pattern = '0;
    endcase
  end

  for (genvar p = 0; p < 3; p++) begin : g_phase
    phase_deadtime #(
      .K_DEADTIME(K_DEADTIME)
    ) u_deadtime (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_leg_cmd (phase_leg(cmd_pattern, 2'(p))),
      .o_high    (gate_high[p]),
      .o_low     (gate_low[p])
    );
  end

  assign o_pattern   = {gate_high, gate_low};
  assign o_step      = step_q;
  assign o_substep   = substep_q;
  assign o_commutate = commutate_q;
  assign o_state     = state_q;
  assign o_fault     = fault_q;

endmodule

// File: tb/tb_commutation_sequencer.sv
// Self-checking bench for commutation_sequencer; the stall scenario is compiled with STALL_DETECT_EN.
module tb_commutation_sequencer;

  localparam int K_N     = 10;
  localparam int K_DT    = 4;
  localparam int K_STALL = 50;
  localparam int PW      = $clog2(K_N + 1);
  localparam int SW      = $clog2(K_N);

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_enable, i_brake, i_direction;
  logic          i_step_trigger, i_step_dir, i_polarity_rev;
  logic [2:0]    i_force_step_value;
  logic          i_force_step_trigger;
  logic [PW-1:0] i_power;
  logic [5:0]    o_pattern;
  logic [2:0]    o_step;
  logic [SW-1:0] o_substep;
  logic          o_commutate;
  logic [1:0]    o_state;
  logic          o_fault;

  int n_checks = 0;
  int n_fails  = 0;
  int m_pos;

  logic [5:0] lut_tbl [6] = '{6'b001100, 6'b010100, 6'b010001, 6'b100001, 6'b100010, 6'b001010};

  commutation_sequencer #(
    .K_NSUBSTEPS(K_N), .K_DEADTIME(K_DT), .K_STALL_CYCLES(K_STALL)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_brake(i_brake),
    .i_direction(i_direction), .i_step_trigger(i_step_trigger), .i_step_dir(i_step_dir),
    .i_polarity_rev(i_polarity_rev), .i_force_step_value(i_force_step_value),
    .i_force_step_trigger(i_force_step_trigger), .i_power(i_power),
    .o_pattern(o_pattern), .o_step(o_step), .o_substep(o_substep),
    .o_commutate(o_commutate), .o_state(o_state), .o_fault(o_fault)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "[TB] timeout");
  end

  // Commanded pattern derived from rotor position (sector*K_N + substep) and the sector table.
  function automatic logic [5:0] model_cmd(input int st, input int pos, input int pwr, input bit dir);
    logic [5:0] p;
    int step, sub, drive;
    step = pos / K_N;
    sub  = pos % K_N;
    p    = 6'b000000;
    if (st == 1) begin
      drive = dir ? (step + 5) % 6 : (step + 1) % 6;
      p = lut_tbl[drive];
      if (!(pwr > sub)) p[5:3] = 3'b000;
    end else if (st == 2) begin
      p = 6'b000111;
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic pulse(input bit dir);
    i_step_dir     = dir;
    i_step_trigger = 1'b1;
    tick();
    i_step_trigger = 1'b0;
  endtask

  task automatic force_step(input logic [2:0] v);
    i_force_step_value   = v;
    i_force_step_trigger = 1'b1;
    tick();
    i_force_step_trigger = 1'b0;
  endtask

  task automatic model_move(input bit up);
    m_pos = up ? (m_pos + 1) % (6 * K_N) : (m_pos + 6 * K_N - 1) % (6 * K_N);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_enable = 1'b0; i_brake = 1'b0; i_direction = 1'b0;
    i_step_trigger = 1'b0; i_step_dir = 1'b0; i_polarity_rev = 1'b0;
    i_force_step_value = 3'd0; i_force_step_trigger = 1'b0; i_power = '0;
    #12;
    n_checks++; if (o_pattern !== 6'b0) begin n_fails++; $display("[TB] FAIL reset_pattern got=%b exp=000000", o_pattern); end
    n_checks++; if (o_step !== 3'd5) begin n_fails++; $display("[TB] FAIL reset_step got=%0d exp=5", o_step); end
    n_checks++; if (o_substep !== '0) begin n_fails++; $display("[TB] FAIL reset_substep got=%0d exp=0", o_substep); end
    n_checks++; if (o_commutate !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_commutate got=%b exp=0", o_commutate); end
    n_checks++; if (o_state !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_state got=%b exp=00", o_state); end
    n_checks++; if (o_fault !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_fault got=%b exp=0", o_fault); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    n_checks++; if (o_state !== 2'b00) begin n_fails++; $display("[TB] FAIL idle_after_reset got=%b exp=00", o_state); end
    m_pos = 5 * K_N;
  endtask

  task automatic test_commutate_up();
    int pulses;
    i_enable = 1'b1; i_power = PW'(K_N); i_direction = 1'b0;
    tick(); tick();
    n_checks++; if (o_state !== 2'b01) begin n_fails++; $display("[TB] FAIL run_state got=%b exp=01", o_state); end
    n_checks++; if (o_pattern !== model_cmd(1, m_pos, K_N, 0)) begin n_fails++; $display("[TB] FAIL run_pattern_step5 got=%b exp=%b", o_pattern, model_cmd(1, m_pos, K_N, 0)); end
    pulses = 0;
    for (int i = 0; i < K_N; i++) begin
      pulse(1'b0);
      model_move(1'b1);
      if (o_commutate === 1'b1) pulses++;
    end
    n_checks++; if (o_step !== 3'(m_pos / K_N)) begin n_fails++; $display("[TB] FAIL up_wrap_step got=%0d exp=%0d", o_step, m_pos / K_N); end
    n_checks++; if (o_substep !== SW'(m_pos % K_N)) begin n_fails++; $display("[TB] FAIL up_wrap_substep got=%0d exp=%0d", o_substep, m_pos % K_N); end
    tick();
    n_checks++; if (pulses != 1) begin n_fails++; $display("[TB] FAIL up_commutate_count got=%0d exp=1", pulses); end
    n_checks++; if (o_commutate !== 1'b0) begin n_fails++; $display("[TB] FAIL commutate_one_cycle got=%b exp=0", o_commutate); end
    n_checks++; if (o_pattern !== model_cmd(1, m_pos, K_N, 0)) begin n_fails++; $display("[TB] FAIL pattern_step0 got=%b exp=%b", o_pattern, model_cmd(1, m_pos, K_N, 0)); end
  endtask

  task automatic test_down_and_force();
    pulse(1'b1);
    model_move(1'b0);
    n_checks++; if (o_step !== 3'(m_pos / K_N) || o_substep !== SW'(m_pos % K_N)) begin n_fails++; $display("[TB] FAIL down_wrap got=%0d/%0d exp=%0d/%0d", o_step, o_substep, m_pos / K_N, m_pos % K_N); end
    n_checks++; if (o_commutate !== 1'b1) begin n_fails++; $display("[TB] FAIL down_commutate got=%b exp=1", o_commutate); end
    i_polarity_rev = 1'b1;
    pulse(1'b1);
    model_move(1'b1);
    i_polarity_rev = 1'b0;
    n_checks++; if (o_step !== 3'(m_pos / K_N) || o_substep !== SW'(m_pos % K_N)) begin n_fails++; $display("[TB] FAIL polarity_rev got=%0d/%0d exp=%0d/%0d", o_step, o_substep, m_pos / K_N, m_pos % K_N); end
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0);
      model_move(1'b1);
    end
    force_step(3'd7);
    n_checks++; if (o_step !== 3'(m_pos / K_N) || o_substep !== SW'(m_pos % K_N)) begin n_fails++; $display("[TB] FAIL force7_ignored got=%0d/%0d exp=%0d/%0d", o_step, o_substep, m_pos / K_N, m_pos % K_N); end
    force_step(3'd3);
    m_pos = 3 * K_N;
    n_checks++; if (o_step !== 3'd3 || o_substep !== '0) begin n_fails++; $display("[TB] FAIL force3 got=%0d/%0d exp=3/0", o_step, o_substep); end
    n_checks++; if (o_commutate !== 1'b0) begin n_fails++; $display("[TB] FAIL force_no_pulse got=%b exp=0", o_commutate); end
  endtask

  task automatic test_force_vs_tick();
    i_step_dir = 1'b0;
    i_step_trigger = 1'b1;
    force_step(3'd2);
    i_step_trigger = 1'b0;
    m_pos = 2 * K_N;
    n_checks++; if (o_step !== 3'd2 || o_substep !== '0) begin n_fails++; $display("[TB] FAIL force_beats_tick got=%0d/%0d exp=2/0", o_step, o_substep); end
    n_checks++; if (o_commutate !== 1'b0) begin n_fails++; $display("[TB] FAIL force_tick_pulse got=%b exp=0", o_commutate); end
  endtask

  task automatic test_power();
    int pwr_list [2] = '{4, 0};
    for (int k = 0; k < 2; k++) begin
      i_power = PW'(pwr_list[k]);
      force_step(3'd3);
      m_pos = 3 * K_N;
      for (int w = 0; w < K_DT + 3; w++) tick();
      for (int s = 0; s < K_N; s++) begin
        if (s > 0) begin
          pulse(1'b0);
          model_move(1'b1);
        end
        tick();
        n_checks++; if (o_pattern !== model_cmd(1, m_pos, pwr_list[k], 0)) begin n_fails++; $display("[TB] FAIL power%0d_sub%0d got=%b exp=%b", pwr_list[k], s, o_pattern, model_cmd(1, m_pos, pwr_list[k], 0)); end
      end
    end
  endtask

  task automatic test_brake_deadtime();
    int off_cnt;
    bit done;
    i_power = PW'(K_N);
    force_step(3'd5);
    m_pos = 5 * K_N;
    for (int w = 0; w < K_DT + 3; w++) tick();
    n_checks++; if (o_pattern !== model_cmd(1, m_pos, K_N, 0)) begin n_fails++; $display("[TB] FAIL pre_brake_pattern got=%b exp=%b", o_pattern, model_cmd(1, m_pos, K_N, 0)); end
    i_brake = 1'b1;
    tick();
    n_checks++; if (o_state !== 2'b10) begin n_fails++; $display("[TB] FAIL brake_state got=%b exp=10", o_state); end
    off_cnt = 0;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      tick();
      n_checks++; if ((o_pattern[5:3] & o_pattern[2:0]) !== 3'b000) begin n_fails++; $display("[TB] FAIL brake_overlap got=%b exp=no_shoot_through", o_pattern); end
      if (o_pattern[3] === 1'b0 && o_pattern[0] === 1'b0) off_cnt++;
      else if (o_pattern[0] === 1'b1) done = 1'b1;
    end
    n_checks++; if (!done) begin n_fails++; $display("[TB] FAIL brake_low_timeout got=%b exp=phase0_low", o_pattern); end
    n_checks++; if (off_cnt != K_DT) begin n_fails++; $display("[TB] FAIL deadtime_len got=%0d exp=%0d", off_cnt, K_DT); end
    n_checks++; if (o_pattern !== 6'b000111) begin n_fails++; $display("[TB] FAIL brake_pattern got=%b exp=000111", o_pattern); end
  endtask

  task automatic test_enable_mid_deadtime();
    i_brake = 1'b0;
    tick(); tick();
    n_checks++; if (o_pattern[3] !== 1'b0 || o_pattern[0] !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_dt_phase0 got=%b exp=phase0_off", o_pattern); end
    i_enable = 1'b0;
    tick();
    n_checks++; if (o_state !== 2'b00) begin n_fails++; $display("[TB] FAIL disable_state got=%b exp=00", o_state); end
    tick();
    n_checks++; if (o_pattern !== 6'b0) begin n_fails++; $display("[TB] FAIL disable_pattern got=%b exp=000000", o_pattern); end
  endtask

  task automatic test_random();
    logic [5:0] exp_pat;
    int pwr, old_step;
    bit trig, sdir, rev, exp_com;
    i_enable = 1'b1; i_brake = 1'b0; i_direction = 1'b0; i_polarity_rev = 1'b0;
    pwr = K_N;
    i_power = PW'(pwr);
    force_step(3'd0);
    m_pos = 0;
    for (int w = 0; w < K_DT + 4; w++) tick();
    for (int n = 0; n < 400; n++) begin
      trig = 1'($urandom_range(0, 1));
      sdir = 1'($urandom_range(0, 1));
      rev  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) pwr = $urandom_range(0, K_N);
      i_power = PW'(pwr);
      exp_pat = model_cmd(1, m_pos, pwr, 0);
      i_step_dir = sdir; i_polarity_rev = rev; i_step_trigger = trig;
      tick();
      i_step_trigger = 1'b0;
      old_step = m_pos / K_N;
      if (trig) model_move(!(sdir ^ rev));
      exp_com = trig && (m_pos / K_N != old_step);
      n_checks++; if (o_step !== 3'(m_pos / K_N)) begin n_fails++; $display("[TB] FAIL rnd_step n=%0d got=%0d exp=%0d", n, o_step, m_pos / K_N); end
      n_checks++; if (o_substep !== SW'(m_pos % K_N)) begin n_fails++; $display("[TB] FAIL rnd_substep n=%0d got=%0d exp=%0d", n, o_substep, m_pos % K_N); end
      n_checks++; if (o_commutate !== exp_com) begin n_fails++; $display("[TB] FAIL rnd_commutate n=%0d got=%b exp=%b", n, o_commutate, exp_com); end
      n_checks++; if (o_pattern !== exp_pat) begin n_fails++; $display("[TB] FAIL rnd_pattern n=%0d got=%b exp=%b", n, o_pattern, exp_pat); end
    end
    i_polarity_rev = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    i_power = PW'(K_N);
    i_enable = 1'b0;
    tick();
    i_enable = 1'b1;
    tick();
    n_checks++; if (o_state !== 2'b01) begin n_fails++; $display("[TB] FAIL stall_run_entry got=%b exp=01", o_state); end
    n = 0;
    while (o_state !== 2'b11 && n < 200) begin
      tick();
      n++;
    end
`ifdef STALL_DETECT_EN
    n_checks++; if (n != K_STALL) begin n_fails++; $display("[TB] FAIL stall_cycles got=%0d exp=%0d", n, K_STALL); end
    n_checks++; if (o_fault !== 1'b1) begin n_fails++; $display("[TB] FAIL stall_fault got=%b exp=1", o_fault); end
    tick();
    n_checks++; if (o_pattern !== 6'b0) begin n_fails++; $display("[TB] FAIL fault_pattern got=%b exp=000000", o_pattern); end
    i_brake = 1'b1; tick(); i_brake = 1'b0; tick();
    n_checks++; if (o_state !== 2'b11 || o_fault !== 1'b1) begin n_fails++; $display("[TB] FAIL fault_held got=%b/%b exp=11/1", o_state, o_fault); end
    i_enable = 1'b0;
    tick();
    n_checks++; if (o_state !== 2'b00 || o_fault !== 1'b0) begin n_fails++; $display("[TB] FAIL fault_clear got=%b/%b exp=00/0", o_state, o_fault); end
`else
    n_checks++; if (n != 200 || o_state !== 2'b01) begin n_fails++; $display("[TB] FAIL no_stall got=%0d/%b exp=200/01", n, o_state); end
    n_checks++; if (o_fault !== 1'b0) begin n_fails++; $display("[TB] FAIL fault_tied got=%b exp=0", o_fault); end
`endif
  endtask

  task automatic test_async_reset();
    i_enable = 1'b1; i_brake = 1'b0;
    tick(); tick(); tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_pattern !== 6'b0) begin n_fails++; $display("[TB] FAIL async_pattern got=%b exp=000000", o_pattern); end
    n_checks++; if (o_state !== 2'b00 || o_step !== 3'd5 || o_substep !== '0) begin n_fails++; $display("[TB] FAIL async_state got=%b/%0d/%0d exp=00/5/0", o_state, o_step, o_substep); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    $display("[TB] starting commutation_sequencer bench");
    test_reset();
    test_commutate_up();
    test_down_and_force();
    test_force_vs_tick();
    test_power();
    test_brake_deadtime();
    test_enable_mid_deadtime();
    test_random();
    test_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
